// File: rtl/imm_encoder_if.sv
// Valid/ready bus between the immediate packer, its item source and its word sink.
interface imm_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            ImmSrc;
  logic [31:0]           imm;
  logic [31:0]           base;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] out_addr;

  // Item source and word sink side
  modport master (
    output in_valid, ImmSrc, imm, base, out_ready,
    input  in_ready, out_valid, instr, out_addr
  );

  // Encoder side
  modport slave (
    input  in_valid, ImmSrc, imm, base, out_ready,
    output in_ready, out_valid, instr, out_addr
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs immediates into RISC-V I/S/B/J/U instruction fields over a two-stage
// valid/ready pipeline; out-of-range items are dropped and counted.
module imm_encoder #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  imm_encoder_if.slave             bus,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;

  typedef struct packed {
    logic [2:0]      src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] base;
    logic            legal;
  } s1_t;

  // True when imm is representable in the format's immediate field
  function automatic logic imm_legal(input logic [2:0] src, input logic [XLEN-1:0] v);
    logic ok;
    ok = 1'b0;
    case (src)
      FMT_I, FMT_S: ok = (&v[31:11]) | ~(|v[31:11]);
      FMT_B:        ok = ((&v[31:12]) | ~(|v[31:12])) & ~v[0];
      FMT_J:        ok = ((&v[31:20]) | ~(|v[31:20])) & ~v[0];
      FMT_U:        ok = ~(|v[11:0]);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Overlay the immediate fields onto the template word
  function automatic logic [XLEN-1:0] imm_pack(input logic [2:0] src,
                                               input logic [XLEN-1:0] v,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = b;
    case (src)
      FMT_I: r[31:20] = v[11:0];
      FMT_S: begin
        r[31:25] = v[11:5];
        r[11:7]  = v[4:0];
      end
      FMT_B: begin
        r[31]    = v[12];
        r[30:25] = v[10:5];
        r[11:8]  = v[4:1];
        r[7]     = v[11];
      end
      FMT_J: begin
        r[31]    = v[20];
        r[30:21] = v[10:1];
        r[20]    = v[11];
        r[19:12] = v[19:12];
      end
      FMT_U:   r[31:12] = v[31:12];
      default: r = b;
    endcase
    return r;
  endfunction

  s1_t                   s1_q;
  logic                  s1_valid;
  logic                  out_valid_q;
  logic [XLEN-1:0]       instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic s2_free;
  logic s1_adv;
  logic in_accept;
  logic out_hs;

  // Handshake qualifiers; in_ready is combinational with no skid buffer
  assign s2_free   = !out_valid_q || bus.out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_accept = bus.in_valid && bus.in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;

  assign bus.in_ready  = !s1_valid || s2_free;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.out_addr  = addr_q;

  // Stage 1: capture item and its legality
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_q     <= '{src:   bus.ImmSrc,
                    imm:   bus.imm,
                    base:  bus.base,
                    legal: imm_legal(bus.ImmSrc, bus.imm)};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: pack legal items and hold them until the sink takes them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
    end else if (s1_adv) begin
      out_valid_q <= s1_q.legal;
      if (s1_q.legal) begin
        instr_q <= imm_pack(s1_q.src, s1_q.imm, s1_q.base);
      end
    end else if (out_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  // Word address of the presented word; clr overrides the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (clr) begin
      addr_q <= '0;
    end else if (out_hs) begin
      addr_q <= addr_q + ADDR_WIDTH'(4);
    end
  end

  // Error flag and saturating count of dropped items; clr overrides counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (s1_adv && !s1_q.legal) begin
      err_sticky <= 1'b1;
      if (err_cnt != {ERR_CNT_WIDTH{1'b1}}) begin
        err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomised and directed bench for imm_encoder against an arithmetic reference model.
module tb_imm_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wclr;
  logic       err_sticky, w_err_sticky;
  logic [7:0] err_cnt, w_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int timeouts = 0;

  logic [2:0]  a_src[$];
  logic [31:0] a_imm[$];
  logic [31:0] a_base[$];
  logic [31:0] g_instr[$];
  logic [31:0] g_addr[$];

  imm_encoder_if #(.ADDR_WIDTH(32)) mb ();
  imm_encoder_if #(.ADDR_WIDTH(4))  wb ();

  imm_encoder #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(mb.slave),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  imm_encoder #(.ADDR_WIDTH(4), .ERR_CNT_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst), .clr(wclr), .bus(wb.slave),
    .err_sticky(w_err_sticky), .err_cnt(w_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: is imm inside the signed range / alignment of its format
  function automatic bit legal_of(input logic [2:0] s, input logic [31:0] im);
    longint v;
    v = longint'($signed(im));
    case (s)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      3'd3:       return (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
      3'd4:       return (im % 32'd4096) == 32'd0;
      default:    return 1'b0;
    endcase
  endfunction

  // Reference: template with immediate fields overwritten, via shifts and masks
  function automatic logic [31:0] model_encode(input logic [2:0] s, input logic [31:0] im,
                                               input logic [31:0] b);
    logic [31:0] mask, f;
    case (s)
      3'd0: begin
        mask = 32'hFFF0_0000;
        f    = (im & 32'hFFF) << 20;
      end
      3'd1: begin
        mask = 32'hFE00_0F80;
        f    = (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
      end
      3'd2: begin
        mask = 32'hFE00_0F80;
        f    = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) |
               (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7);
      end
      3'd3: begin
        mask = 32'hFFFF_F000;
        f    = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
               (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12);
      end
      default: begin
        mask = 32'hFFFF_F000;
        f    = im & 32'hFFFF_F000;
      end
    endcase
    return (b & ~mask) | f;
  endfunction

  // Standard RISC-V immediate decode, used for the round-trip property
  function automatic logic [31:0] decode_imm(input logic [2:0] s, input logic [31:0] w);
    case (s)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_legal(input logic [2:0] s);
    logic [31:0] r;
    r = $urandom;
    case (s)
      3'd0, 3'd1: return {{20{r[11]}}, r[11:0]};
      3'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       return {{11{r[20]}}, r[20:1], 1'b0};
      3'd4:       return {r[31:12], 12'b0};
      default:    return r;
    endcase
  endfunction

  task automatic clear_q();
    a_src.delete(); a_imm.delete(); a_base.delete();
    g_instr.delete(); g_addr.delete();
  endtask

  // One clock on the main DUT: drive, sample before the edge, log accepts/handshakes
  task automatic tick(input bit v, input logic [2:0] s, input logic [31:0] im,
                      input logic [31:0] b, input bit ordy, input bit c,
                      output bit acc, output bit ohs);
    mb.in_valid = v; mb.ImmSrc = s; mb.imm = im; mb.base = b;
    mb.out_ready = ordy; clr = c;
    #1;
    acc = mb.in_valid && mb.in_ready;
    ohs = mb.out_valid && mb.out_ready;
    if (acc) begin
      a_src.push_back(s); a_imm.push_back(im); a_base.push_back(b);
    end
    if (ohs) begin
      g_instr.push_back(mb.instr); g_addr.push_back(32'(mb.out_addr));
    end
    @(negedge clk); #1;
  endtask

  task automatic send_one(input logic [2:0] s, input logic [31:0] im, input logic [31:0] b);
    bit acc, ohs;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1'b1, s, im, b, 1'b1, 1'b0, acc, ohs);
      done = acc;
    end
    if (!done) timeouts++;
    repeat (4) tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
  endtask

  task automatic test_reset();
    bit acc, ohs;
    n_chk++; if (mb.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", mb.out_valid); else n_pass++;
    n_chk++; if (mb.out_addr !== 32'd0) $display("FAIL rst_out_addr got=%h exp=0", mb.out_addr); else n_pass++;
    n_chk++; if (mb.instr !== 32'd0) $display("FAIL rst_instr got=%h exp=0", mb.instr); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL rst_err_sticky got=%b exp=0", err_sticky); else n_pass++;
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got=%h exp=0", err_cnt); else n_pass++;
    rst = 1'b1;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (mb.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", mb.in_ready); else n_pass++;
  endtask

  task automatic test_directed();
    bit acc, ohs;
    int n;
    int e;
    logic [31:0] exp_w[4];
    exp_w = '{32'h8000_0013, 32'h7E00_2FA3, 32'hFE00_0EE3, 32'h1234_5037};
    clear_q();
    tick(1'b1, 3'd0, 32'hFFFF_F800, 32'h0000_0013, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (acc !== 1'b1) $display("FAIL dir_i_accept got=%b exp=1", acc); else n_pass++;
    n = 1;
    while (!mb.out_valid && n < 8) begin
      tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
      n++;
    end
    n_chk++; if (n !== 2) $display("FAIL dir_latency got=%0d exp=2", n); else n_pass++;
    repeat (3) tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    send_one(3'd1, 32'h0000_07FF, 32'h0000_2023);
    send_one(3'd2, 32'h0000_0003, 32'h0000_0063);
    n_chk++; if (err_sticky !== 1'b1) $display("FAIL dir_b_sticky got=%b exp=1", err_sticky); else n_pass++;
    n_chk++; if (err_cnt !== 8'd1) $display("FAIL dir_b_cnt got=%0d exp=1", err_cnt); else n_pass++;
    n_chk++; if (g_instr.size() !== 2) $display("FAIL dir_b_dropped got=%0d exp=2", g_instr.size()); else n_pass++;
    send_one(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    send_one(3'd3, 32'h0010_0000, 32'h0000_006F);
    n_chk++; if (err_cnt !== 8'd2) $display("FAIL dir_j_cnt got=%0d exp=2", err_cnt); else n_pass++;
    send_one(3'd4, 32'h1234_5001, 32'h0000_0037);
    n_chk++; if (err_cnt !== 8'd3) $display("FAIL dir_u_cnt got=%0d exp=3", err_cnt); else n_pass++;
    send_one(3'd4, 32'h1234_5000, 32'h0000_0037);
    n_chk++; if (g_instr.size() !== 4) $display("FAIL dir_count got=%0d exp=4", g_instr.size()); else n_pass++;
    e = 0;
    for (int i = 0; i < a_src.size(); i++) begin
      if (legal_of(a_src[i], a_imm[i]) && e < g_instr.size() && e < 4) begin
        n_chk++; if (g_instr[e] !== exp_w[e]) $display("FAIL dir_instr[%0d] got=%h exp=%h", e, g_instr[e], exp_w[e]); else n_pass++;
        n_chk++; if (g_instr[e] !== model_encode(a_src[i], a_imm[i], a_base[i])) $display("FAIL dir_model[%0d] got=%h exp=%h", e, g_instr[e], model_encode(a_src[i], a_imm[i], a_base[i])); else n_pass++;
        n_chk++; if (g_addr[e] !== 32'(4 * e)) $display("FAIL dir_addr[%0d] got=%h exp=%h", e, g_addr[e], 32'(4 * e)); else n_pass++;
        e++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0]  it_src[4];
    logic [31:0] it_imm[4], it_base[4];
    logic [31:0] held;
    int k, early_acc, idx;
    bit stall_ok, acc, ohs, ordy, c;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    send_one(3'd5, 32'd0, 32'd0);
    n_chk++; if (err_cnt !== 8'd1) $display("FAIL bp_err_pre got=%0d exp=1", err_cnt); else n_pass++;
    clear_q();
    for (int i = 0; i < 4; i++) begin
      it_src[i]  = 3'($urandom_range(0, 4));
      it_imm[i]  = rand_legal(it_src[i]);
      it_base[i] = $urandom;
    end
    k = 0; early_acc = 0; stall_ok = 1'b1; held = '0;
    for (int cyc = 0; cyc < 40 && g_instr.size() < 4; cyc++) begin
      ordy = (cyc >= 5);
      c    = (g_instr.size() == 3) && mb.out_valid && ordy;
      if (cyc == 2) held = mb.instr;
      if (cyc == 4) begin
        n_chk++; if (mb.instr !== held) $display("FAIL bp_hold got=%h exp=%h", mb.instr, held); else n_pass++;
        n_chk++; if (held !== model_encode(it_src[0], it_imm[0], it_base[0])) $display("FAIL bp_first got=%h exp=%h", held, model_encode(it_src[0], it_imm[0], it_base[0])); else n_pass++;
      end
      idx = (k < 4) ? k : 0;
      tick(k < 4, it_src[idx], it_imm[idx], it_base[idx], ordy, c, acc, ohs);
      if (cyc < 5 && acc) early_acc++;
      if (cyc >= 2 && cyc < 5 && acc) stall_ok = 1'b0;
      if (acc) k++;
    end
    n_chk++; if (early_acc !== 2) $display("FAIL bp_early_accepts got=%0d exp=2", early_acc); else n_pass++;
    n_chk++; if (stall_ok !== 1'b1) $display("FAIL bp_in_ready_low got=%b exp=1", stall_ok); else n_pass++;
    n_chk++; if (g_instr.size() !== 4) $display("FAIL bp_count got=%0d exp=4", g_instr.size()); else n_pass++;
    n_chk++; if (a_src.size() !== 4) $display("FAIL bp_accepts got=%0d exp=4", a_src.size()); else n_pass++;
    for (int i = 0; i < 4 && i < g_instr.size(); i++) begin
      n_chk++; if (g_instr[i] !== model_encode(it_src[i], it_imm[i], it_base[i])) $display("FAIL bp_instr[%0d] got=%h exp=%h", i, g_instr[i], model_encode(it_src[i], it_imm[i], it_base[i])); else n_pass++;
      n_chk++; if (g_addr[i] !== 32'(4 * i)) $display("FAIL bp_addr[%0d] got=%h exp=%h", i, g_addr[i], 32'(4 * i)); else n_pass++;
    end
    n_chk++; if (mb.out_addr !== 32'd0) $display("FAIL bp_clr_addr got=%h exp=0", mb.out_addr); else n_pass++;
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL bp_clr_cnt got=%0d exp=0", err_cnt); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL bp_clr_sticky got=%b exp=0", err_sticky); else n_pass++;
  endtask

  task automatic test_clr_illegal();
    bit acc, ohs;
    send_one(3'd6, 32'd0, 32'd0);
    n_chk++; if (err_cnt !== 8'd1) $display("FAIL ci_pre got=%0d exp=1", err_cnt); else n_pass++;
    tick(1'b1, 3'd7, 32'h1, 32'd0, 1'b1, 1'b0, acc, ohs);
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL ci_cnt got=%0d exp=0", err_cnt); else n_pass++;
    n_chk++; if (err_sticky !== 1'b0) $display("FAIL ci_sticky got=%b exp=0", err_sticky); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit acc, ohs;
    int n_acc;
    logic [2:0] s;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    clear_q();
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      s = 3'($urandom_range(0, 4));
      tick(1'b1, s, rand_legal(s), $urandom, 1'b1, 1'b0, acc, ohs);
      if (acc) n_acc++;
    end
    repeat (4) tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (n_acc !== 20) $display("FAIL b2b_accepts got=%0d exp=20", n_acc); else n_pass++;
    n_chk++; if (g_instr.size() !== 20) $display("FAIL b2b_count got=%0d exp=20", g_instr.size()); else n_pass++;
    for (int i = 0; i < g_instr.size() && i < a_src.size(); i++) begin
      n_chk++; if (g_instr[i] !== model_encode(a_src[i], a_imm[i], a_base[i])) $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, g_instr[i], model_encode(a_src[i], a_imm[i], a_base[i])); else n_pass++;
      n_chk++; if (g_addr[i] !== 32'(4 * i)) $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, g_addr[i], 32'(4 * i)); else n_pass++;
    end
  endtask

  task automatic test_random();
    bit acc, ohs, v, ordy;
    logic [2:0]  s;
    logic [31:0] im;
    int e, nill;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    clear_q();
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 5) < 3;
      s    = 3'($urandom % 8);
      im   = (($urandom % 4) == 0) ? $urandom : rand_legal(s);
      tick(v, s, im, $urandom, ordy, 1'b0, acc, ohs);
    end
    repeat (6) tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    e = 0; nill = 0;
    for (int i = 0; i < a_src.size(); i++) begin
      if (legal_of(a_src[i], a_imm[i])) begin
        if (e < g_instr.size()) begin
          n_chk++; if (g_instr[e] !== model_encode(a_src[i], a_imm[i], a_base[i])) $display("FAIL rnd_instr[%0d] got=%h exp=%h", e, g_instr[e], model_encode(a_src[i], a_imm[i], a_base[i])); else n_pass++;
          n_chk++; if (g_addr[e] !== 32'(4 * e)) $display("FAIL rnd_addr[%0d] got=%h exp=%h", e, g_addr[e], 32'(4 * e)); else n_pass++;
          n_chk++; if (decode_imm(a_src[i], g_instr[e]) !== a_imm[i]) $display("FAIL rnd_roundtrip[%0d] got=%h exp=%h", e, decode_imm(a_src[i], g_instr[e]), a_imm[i]); else n_pass++;
        end
        e++;
      end else begin
        nill++;
      end
    end
    n_chk++; if (g_instr.size() !== e) $display("FAIL rnd_count got=%0d exp=%0d", g_instr.size(), e); else n_pass++;
    n_chk++; if (err_cnt !== 8'((nill > 255) ? 255 : nill)) $display("FAIL rnd_err_cnt got=%0d exp=%0d", err_cnt, nill); else n_pass++;
    n_chk++; if (err_sticky !== (nill > 0)) $display("FAIL rnd_sticky got=%b exp=%b", err_sticky, nill > 0); else n_pass++;
  endtask

  task automatic test_saturation();
    bit acc, ohs;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    for (int i = 0; i < 300; i++) tick(1'b1, 3'd5, $urandom, 32'd0, 1'b1, 1'b0, acc, ohs);
    repeat (3) tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (err_cnt !== 8'hFF) $display("FAIL sat_cnt got=%h exp=ff", err_cnt); else n_pass++;
    n_chk++; if (err_sticky !== 1'b1) $display("FAIL sat_sticky got=%b exp=1", err_sticky); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0] wq[$];
    logic [3:0] exp_a[5];
    int k;
    exp_a = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    k = 0;
    for (int cyc = 0; cyc < 20 && wq.size() < 5; cyc++) begin
      wb.in_valid = (k < 5); wb.ImmSrc = 3'd0; wb.imm = 32'(8 * k);
      wb.base = 32'h13; wb.out_ready = 1'b1;
      #1;
      if (wb.in_valid && wb.in_ready) k++;
      if (wb.out_valid && wb.out_ready) wq.push_back(wb.out_addr);
      @(negedge clk); #1;
    end
    wb.in_valid = 1'b0;
    n_chk++; if (wq.size() !== 5) $display("FAIL wrap_count got=%0d exp=5", wq.size()); else n_pass++;
    for (int i = 0; i < 5 && i < wq.size(); i++) begin
      n_chk++; if (wq[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, wq[i], exp_a[i]); else n_pass++;
    end
    n_chk++; if (w_err_cnt !== 8'd0) $display("FAIL wrap_err got=%0d exp=0", w_err_cnt); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bit acc, ohs;
    logic [31:0] c_imm;
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, acc, ohs);
    send_one(3'd0, 32'h5, 32'h13);
    send_one(3'd5, 32'h0, 32'h0);
    tick(1'b1, 3'd1, 32'h10, 32'h2023, 1'b0, 1'b0, acc, ohs);
    tick(1'b1, 3'd0, 32'h20, 32'h13, 1'b0, 1'b0, acc, ohs);
    n_chk++; if (mb.out_valid !== 1'b1) $display("FAIL mid_full got=%b exp=1", mb.out_valid); else n_pass++;
    #2; rst = 1'b0; #1;
    n_chk++; if (mb.out_valid !== 1'b0) $display("FAIL mid_out_valid got=%b exp=0", mb.out_valid); else n_pass++;
    n_chk++; if (err_cnt !== 8'd0) $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
    n_chk++; if (mb.out_addr !== 32'd0) $display("FAIL mid_out_addr got=%h exp=0", mb.out_addr); else n_pass++;
    @(negedge clk); #1;
    rst = 1'b1;
    clear_q();
    tick(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc, ohs);
    n_chk++; if (mb.in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b exp=1", mb.in_ready); else n_pass++;
    c_imm = rand_legal(3'd3);
    send_one(3'd3, c_imm, 32'h0000_00EF);
    n_chk++; if (g_instr.size() !== 1) $display("FAIL mid_count got=%0d exp=1", g_instr.size()); else n_pass++;
    if (g_instr.size() > 0) begin
      n_chk++; if (g_addr[0] !== 32'd0) $display("FAIL mid_addr got=%h exp=0", g_addr[0]); else n_pass++;
      n_chk++; if (g_instr[0] !== model_encode(3'd3, c_imm, 32'h0000_00EF)) $display("FAIL mid_instr got=%h exp=%h", g_instr[0], model_encode(3'd3, c_imm, 32'h0000_00EF)); else n_pass++;
    end
  endtask

  initial begin
    mb.in_valid = 1'b0; mb.ImmSrc = 3'd0; mb.imm = 32'd0; mb.base = 32'd0; mb.out_ready = 1'b0;
    wb.in_valid = 1'b0; wb.ImmSrc = 3'd0; wb.imm = 32'd0; wb.base = 32'd0; wb.out_ready = 1'b1;
    rst = 1'b0; clr = 1'b0; wclr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_directed();
    test_backpressure();
    test_clr_illegal();
    test_back_to_back();
    test_random();
    test_saturation();
    test_wrap();
    test_reset_midstream();
    n_chk++; if (timeouts !== 0) $display("FAIL accept_timeouts got=%0d exp=0", timeouts); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate decode: packs a 32-bit signed/unsigned immediate into the I/S/B/J/U bit positions of a RISC-V instruction word.
- Range-checks each immediate against its format.
- Streams encoded words, each paired with a sequential instruction-memory word address, to the instruction-memory loader and test-program generator.
- Two-stage valid/ready pipeline, full throughput, with sticky error reporting.

Parameters:
- ADDR_WIDTH, 32, width of out_addr; the address counter wraps modulo 2^ADDR_WIDTH.
- ERR_CNT_WIDTH, 8, width of err_cnt; the counter saturates.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  input item valid.
- in_ready  out  1  input item accepted when in_valid && in_ready.
- ImmSrc  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal.
- imm  in  32  immediate value (byte offset for B/J; full upper value for U).
- base  in  32  instruction template; all non-immediate fields (opcode, rd, rs1, rs2, funct) are taken from here.
- clr  in  1  synchronous clear of out_addr counter, err_sticky and err_cnt.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- instr  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  byte address of instr.
- err_sticky  out  1  set on any rejected item.
- err_cnt  out  ERR_CNT_WIDTH  count of rejected items, saturating.

Behaviour:
- Reset (rst low, asynchronous):
  - both stage valids, out_valid, err_sticky, err_cnt and out_addr go to 0; instr goes to 0.
  - in_ready is 1 from the first cycle after release.
- Stage 1 (S1), on accept, registers:
  - ImmSrc, imm and base;
  - legality:
    - I/S: imm[31:11] all equal;
    - B: imm[31:12] all equal and imm[0]==0;
    - J: imm[31:20] all equal and imm[0]==0;
    - U: imm[11:0]==0;
    - ImmSrc 101–111: illegal.
- Stage 2 (S2) packing:
  - Result is base with only the immediate fields replaced; all other base bits pass through unchanged.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Illegal items:
  - never reach S2 and are never emitted;
  - when S1 advances an illegal item: err_sticky<=1, err_cnt<=err_cnt+1, saturating at all-ones.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - S1 advances when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational, no skid).
  - Legal items advancing load S2 and set out_valid. out_valid and instr hold stable until handshake.
- Latency and throughput:
  - Accept in cycle N → out_valid in cycle N+2 when unstalled.
  - One item per cycle sustained.
  - Order preserved; no loss or duplication under any out_ready pattern.
- Address:
  - out_addr is the address of the word currently presented.
  - It increments by 4 on each output handshake and wraps to 0 past 2^ADDR_WIDTH−4.
- clr:
  - Next edge: out_addr<=0, err_sticky<=0, err_cnt<=0. Pipeline contents are unaffected.
  - If clr coincides with an output handshake or an illegal advance, clr wins: address 0, no error counted.
- Round-trip invariant: for every emitted word, decoding instr with the same ImmSrc reproduces imm exactly.

Test Plan:
- I-type, ImmSrc=000, imm=0xFFFFF800, base=0x00000013, out_ready=1 → instr=0x80000013, out_addr=0x0, out_valid exactly 2 cycles after accept.
- S-type, ImmSrc=001, imm=0x000007FF, base=0x00002023 → instr=0x7E002FA3, out_addr=0x4.
- B-type, imm=0x00000003 → nothing emitted, err_sticky=1, err_cnt=1. Then B-type, imm=0xFFFFFFFC, base=0x00000063 → instr=0xFE000EE3. Then J-type, imm=0x00100000 → err_cnt=2. Then U-type, imm=0x12345001 → err_cnt=3. Then U-type, imm=0x12345000, base=0x00000037 → instr=0x12345037.
- Backpressure: stream 4 legal items with out_ready held low 5 cycles → in_ready low after 2 accepts; items emerge in order at out_addr 0x0, 0x4, 0x8, 0xC with no duplicates. Pulse clr coincident with the 4th handshake → out_addr=0, err_cnt=0.
- Address wrap (ADDR_WIDTH=4): emit 5 items → out_addr sequence 0x0, 0x4, 0x8, 0xC, 0x0.
- Reset mid-stream: rst low with S1 and S2 full → out_valid=0, err_cnt=0, out_addr=0 immediately (asynchronous); after release, in_ready=1 and the first new item emits at out_addr 0x0.
